// File: rtl/frame_writer.sv
// Rectangle-fill / full-clear writer for the 240x320 3-bpp image memory.
// Commands are clipped to the image and written out row-major, one pixel per cycle.
module frame_writer #(
    parameter int H_IMAGE = 240,
    parameter int V_IMAGE = 320,
    parameter int ADDR_W  = 17
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_clear,
    input  logic [10:0]       cmd_x,
    input  logic [10:0]       cmd_y,
    input  logic [10:0]       cmd_w,
    input  logic [10:0]       cmd_h,
    input  logic [2:0]        cmd_color,
    input  logic              wr_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_data,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              cmd_error
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // SETUP | compute row base address and clip limits
    // WRITE | one pixel write per unstalled cycle
    // DONE  | done pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_t;

    state_t            state;
    logic [10:0]       x_s, y_s, w_s, h_s;
    logic [10:0]       col, row, x_last, y_last;
    logic [ADDR_W-1:0] row_base;
    logic              writing;

    logic              cmd_bad;
    logic [10:0]       x_sel, y_sel, w_sel, h_sel;
    logic [11:0]       x_sum, y_sum;
    logic [10:0]       x_last_c, y_last_c;
    logic [ADDR_W-1:0] row_base_c;

    always_comb begin
        cmd_bad = 1'b0;
        x_sel   = cmd_x;
        y_sel   = cmd_y;
        w_sel   = cmd_w;
        h_sel   = cmd_h;
        if (cmd_clear) begin
            x_sel = 11'd0;
            y_sel = 11'd0;
            w_sel = 11'(H_IMAGE);
            h_sel = 11'(V_IMAGE);
        end else begin
            cmd_bad = (cmd_x >= 11'(H_IMAGE)) || (cmd_y >= 11'(V_IMAGE)) ||
                      (cmd_w == 11'd0) || (cmd_h == 11'd0);
        end
    end

    // 12-bit sums so x+w / y+h cannot wrap before clipping
    assign x_sum      = {1'b0, x_s} + {1'b0, w_s};
    assign y_sum      = {1'b0, y_s} + {1'b0, h_s};
    assign x_last_c   = (x_sum >= 12'(H_IMAGE)) ? 11'(H_IMAGE - 1) : 11'(x_sum - 12'd1);
    assign y_last_c   = (y_sum >= 12'(V_IMAGE)) ? 11'(V_IMAGE - 1) : 11'(y_sum - 12'd1);
    assign row_base_c = ADDR_W'(y_s) * ADDR_W'(H_IMAGE) + ADDR_W'(x_s);

    // Stall must suppress the write in the same cycle it is asserted.
    assign mem_we = writing & ~wr_stall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_error <= 1'b0;
            writing   <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= 3'd0;
            row_base  <= '0;
            x_s       <= 11'd0;
            y_s       <= 11'd0;
            w_s       <= 11'd0;
            h_s       <= 11'd0;
            col       <= 11'd0;
            row       <= 11'd0;
            x_last    <= 11'd0;
            y_last    <= 11'd0;
        end else begin
            cmd_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_bad) begin
                            cmd_error <= 1'b1;
                        end else begin
                            x_s       <= x_sel;
                            y_s       <= y_sel;
                            w_s       <= w_sel;
                            h_s       <= h_sel;
                            mem_data  <= cmd_color;
                            busy      <= 1'b1;
                            cmd_ready <= 1'b0;
                            state     <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    row_base <= row_base_c;
                    mem_addr <= row_base_c;
                    x_last   <= x_last_c;
                    y_last   <= y_last_c;
                    col      <= x_s;
                    row      <= y_s;
                    writing  <= 1'b1;
                    state    <= WRITE;
                end
                WRITE: begin
                    if (!wr_stall) begin
                        if (col == x_last) begin
                            if (row == y_last) begin
                                writing <= 1'b0;
                                done    <= 1'b1;
                                state   <= DONE;
                            end else begin
                                col      <= x_s;
                                row      <= row + 11'd1;
                                row_base <= row_base + ADDR_W'(H_IMAGE);
                                mem_addr <= row_base + ADDR_W'(H_IMAGE);
                            end
                        end else begin
                            col      <= col + 11'd1;
                            mem_addr <= mem_addr + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/frame_writer.md
# frame_writer

Command-driven writer for the 240x320, 3-bit-per-pixel video image memory. It accepts rectangle-fill and full-frame-clear commands over a valid/ready handshake and clips each rectangle to the image. It then emits one row-major memory write per cycle (address = y*H_IMAGE + x) on the image memory's write port. It is the producer side of the framebuffer read by the display scan-out path.

## Interface
- H_IMAGE, 240, image width in pixels
- V_IMAGE, 320, image height in pixels
- ADDR_W, 17, memory address width, $clog2(H_IMAGE*V_IMAGE)
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_clear  in  1  fill entire frame; cmd_x/y/w/h ignored
- cmd_x, cmd_y  in  11 each  top-left corner of the rectangle
- cmd_w, cmd_h  in  11 each  rectangle width and height in pixels
- cmd_color  in  3  fill color {r,g,b}
- wr_stall  in  1  write port busy; pause writes
- mem_addr  out  ADDR_W  write address
- mem_data  out  3  write data
- mem_we  out  1  write enable
- busy  out  1  high in SETUP, WRITE and DONE
- done  out  1  one-cycle pulse after the last write of a command
- cmd_error  out  1  one-cycle pulse on a rejected command

## Operation
- Handshake: a command is accepted on a rising edge where cmd_valid & cmd_ready. All cmd_* inputs are sampled on that edge only.
- Rejection: without cmd_clear, a command is rejected if cmd_x >= H_IMAGE, cmd_y >= V_IMAGE, cmd_w == 0 or cmd_h == 0.
  - Rejected command: cmd_error pulses for the following cycle, the state stays IDLE, no write occurs, and cmd_ready stays 1.
- cmd_clear is treated as x=0, y=0, w=H_IMAGE, h=V_IMAGE.
- Clipping uses 12-bit sums to avoid overflow:
  - x_last = min(x+w, H_IMAGE) - 1
  - y_last = min(y+h, V_IMAGE) - 1
- State machine:
  - IDLE -> SETUP on a valid accepted command.
  - SETUP (1 cycle): compute row_base = y*H_IMAGE + x (constant multiply), the clip limits, col = x and row = y. Go to WRITE.
  - WRITE: mem_we = !wr_stall. mem_addr = row_base + (col - x), or an equivalent registered current address. mem_data = latched color.
    - On each non-stalled cycle, advance col. At col == x_last: col <= x, row_base += H_IMAGE, row++.
    - At col == x_last and row == y_last: go to DONE.
  - DONE (1 cycle): done = 1. Go to IDLE.
- wr_stall in WRITE: mem_we = 0, and address and counters hold. wr_stall is ignored in other states.
- mem_we is 0 outside WRITE. mem_addr and mem_data are don't-care when mem_we = 0, but must be held stable.
- Reset values (asynchronous, while reset_n = 0):
  - state IDLE
  - cmd_ready = 1
  - mem_we = 0, busy = 0, done = 0, cmd_error = 0
  - mem_addr = 0, mem_data = 0
- Reset mid-command aborts immediately: no further writes, no done pulse. The block accepts a new command on the first edge after release.

## Timing
- Edge E0 accepts a command. SETUP runs during cycle E0..E1. The first write is presented during E1..E2 and committed at E2.
- An unstalled N-pixel command writes on N consecutive cycles. done is high during the cycle after the last write.
- cmd_ready returns to 1 two cycles after the last write, so the next command can be accepted no earlier than that edge.
- Each stalled cycle delays all later writes and done by exactly one cycle.
- cmd_error is high in the cycle directly after the rejecting edge.
- Throughput: one pixel per cycle. A full clear takes 76800 write cycles plus 3 overhead cycles.

## Test plan
- Reset: hold reset_n = 0 with cmd_valid = 1.
  - During reset: cmd_ready = 1, mem_we = 0, busy = 0, done = 0, cmd_error = 0.
  - After release, a command is accepted on the first edge.
- Rect (10,5) w=2 h=2 color 3'b101: mem_we on 4 consecutive cycles with addr 1210, 1211, 1450, 1451 and data 5.
  - Cycles: first write is 1 cycle after SETUP; done pulses once afterwards; busy falls with the return to IDLE.
- Clip (238,319) w=5 h=4 color 3'b001: exactly 2 writes, addr 76798 and 76799, then done. No address >= 76800 appears.
- Errors: x=240, then y=320, then w=0, each with h=1. Each gives one cmd_error pulse and zero mem_we cycles; cmd_ready never drops.
- Stall: 2x2 rect at (0,0), with wr_stall high for 3 cycles after the first write.
  - mem_we = 0 and addr held at 1 during the stall.
  - Remaining writes 1, 240, 241 follow; done is 3 cycles later than in the unstalled run.
- Clear with color 3'b111: 76800 writes covering 0..76799 in order, then done.
  - Second run: pull reset_n low after 1000 writes. mem_we drops immediately with no done pulse; a fresh command afterwards runs normally.
